// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the MIPS front-end control blocks.
//   REG_ADDR_W       : register address width
//   DRAIN_CYCLES_DEF : default number of bubble cycles after HALT (ID->WB depth)
//   risk_state_t     : hazard controller FSM encoding
//   reg_match()      : "destination feeds a source of the ID instruction" test,
//                      with register 0 never matching
package pipeline_pkg;

  localparam int REG_ADDR_W       = 5;
  localparam int DRAIN_CYCLES_DEF = 4;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_HALTED = 2'b10
  } risk_state_t;

  function automatic logic reg_match(input logic [REG_ADDR_W-1:0] dst,
                                     input logic [REG_ADDR_W-1:0] rs,
                                     input logic [REG_ADDR_W-1:0] rt,
                                     input logic                  uses_rt);
    return (dst != '0) && ((dst == rs) || (uses_rt && (dst == rt)));
  endfunction

endpackage

// File: rtl/unit_risk_ctrl_if.sv
// Interface between the pipeline datapath and the hazard controller.
// The master modport is the datapath side (drives hazard inputs, receives
// control); the slave modport is the controller side.
//   i_*        : ID/EX/MEM instruction information used for hazard detection
//   o_*        : PC / IF/ID control, bubble request, halt status, stall count
//   o_dbg_state: current controller FSM state, for debug and checkers
interface unit_risk_ctrl_if
  import pipeline_pkg::*;
#(
  parameter int CNT_W = 32
);
  logic [REG_ADDR_W-1:0] i_if_id_rs;
  logic [REG_ADDR_W-1:0] i_if_id_rt;
  logic                  i_uses_rt;
  logic                  i_id_branch;
  logic                  i_id_ex_mem_read;
  logic                  i_id_ex_reg_write;
  logic [REG_ADDR_W-1:0] i_id_ex_dst;
  logic                  i_ex_mem_mem_read;
  logic [REG_ADDR_W-1:0] i_ex_mem_dst;
  logic                  i_take;
  logic                  i_halt;

  logic                  o_risk;
  logic                  o_pc_write;
  logic                  o_if_id_write;
  logic                  o_if_id_flush;
  logic                  o_halted;
  logic [CNT_W-1:0]      o_stall_count;
  risk_state_t           o_dbg_state;

  modport master (
    output i_if_id_rs, i_if_id_rt, i_uses_rt, i_id_branch,
           i_id_ex_mem_read, i_id_ex_reg_write, i_id_ex_dst,
           i_ex_mem_mem_read, i_ex_mem_dst, i_take, i_halt,
    input  o_risk, o_pc_write, o_if_id_write, o_if_id_flush, o_halted,
           o_stall_count, o_dbg_state
  );

  modport slave (
    input  i_if_id_rs, i_if_id_rt, i_uses_rt, i_id_branch,
           i_id_ex_mem_read, i_id_ex_reg_write, i_id_ex_dst,
           i_ex_mem_mem_read, i_ex_mem_dst, i_take, i_halt,
    output o_risk, o_pc_write, o_if_id_write, o_if_id_flush, o_halted,
           o_stall_count, o_dbg_state
  );

endinterface

// File: rtl/unit_risk_ctrl_risk_detect.sv
// Combinational hazard comparison for the instruction in ID.
//   lu   : load in EX feeds a source of the ID instruction (load-use)
//   br1  : ID branch/jr needs a register still being produced in EX
//   br2  : ID branch/jr needs a register being loaded in MEM
//   stall: any of the above
// Kept free of state so the forwarding unit can reuse it.
module risk_detect
  import pipeline_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rt,
  input  logic                  uses_rt,
  input  logic                  id_branch,
  input  logic                  id_ex_mem_read,
  input  logic                  id_ex_reg_write,
  input  logic [REG_ADDR_W-1:0] id_ex_dst,
  input  logic                  ex_mem_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_mem_dst,
  output logic                  lu,
  output logic                  br1,
  output logic                  br2,
  output logic                  stall
);

  logic ex_match;
  logic mem_match;

  assign ex_match  = reg_match(id_ex_dst, rs, rt, uses_rt);
  assign mem_match = reg_match(ex_mem_dst, rs, rt, uses_rt);

  assign lu    = id_ex_mem_read & ex_match;
  assign br1   = id_branch & id_ex_reg_write & ex_match;
  assign br2   = id_branch & ex_mem_mem_read & mem_match;
  assign stall = lu | br1 | br2;

endmodule

// File: rtl/unit_risk_ctrl.sv
// Hazard detection and front-end sequencing controller.
// Detects load-use / branch-operand hazards on the ID instruction, gates the
// PC and IF/ID writes, squashes the delay slot on taken transfers and drains
// the pipeline after HALT before reporting halted.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_enable       : debug run/step enable; low freezes the controller
//   bus (slave)    : hazard inputs and front-end control outputs
// Optional build macro RISK_STALL_COUNT_EN: when defined, o_stall_count is a
// saturating count of stall cycles; otherwise it is tied to zero.
module unit_risk_ctrl
  import pipeline_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int CNT_W        = 32
)(
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_enable,
  unit_risk_ctrl_if.slave bus
);

  localparam int DW = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  risk_state_t   state, state_next;
  logic [DW-1:0] drain_cnt, drain_next;

  logic hz_lu, hz_br1, hz_br2, hz_stall;

  risk_detect u_detect (
    .rs              (bus.i_if_id_rs),
    .rt              (bus.i_if_id_rt),
    .uses_rt         (bus.i_uses_rt),
    .id_branch       (bus.i_id_branch),
    .id_ex_mem_read  (bus.i_id_ex_mem_read),
    .id_ex_reg_write (bus.i_id_ex_reg_write),
    .id_ex_dst       (bus.i_id_ex_dst),
    .ex_mem_mem_read (bus.i_ex_mem_mem_read),
    .ex_mem_dst      (bus.i_ex_mem_dst),
    .lu              (hz_lu),
    .br1             (hz_br1),
    .br2             (hz_br2),
    .stall           (hz_stall)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= ST_RUN;
      drain_cnt <= '0;
    end else if (i_enable) begin
      state     <= state_next;
      drain_cnt <= drain_next;
    end
  end

  // Outputs are combinational so that reset and enable take effect in the
  // same cycle they are asserted.
  always_comb begin
    state_next        = state;
    drain_next        = drain_cnt;
    bus.o_risk        = 1'b0;
    bus.o_pc_write    = 1'b1;
    bus.o_if_id_write = 1'b1;
    bus.o_if_id_flush = 1'b0;
    bus.o_halted      = 1'b0;
    if (i_reset) begin
      state_next = ST_RUN;
    end else if (!i_enable) begin
      bus.o_pc_write    = 1'b0;
      bus.o_if_id_write = 1'b0;
      bus.o_halted      = (state == ST_HALTED);
    end else begin
      unique case (state)
        ST_RUN: begin
          if (hz_stall) begin
            // HALT/take in ID wait until the operands are available.
            bus.o_risk        = 1'b1;
            bus.o_pc_write    = 1'b0;
            bus.o_if_id_write = 1'b0;
          end else if (bus.i_halt) begin
            // HALT itself moves on; nothing behind it is fetched.
            bus.o_pc_write    = 1'b0;
            bus.o_if_id_write = 1'b0;
            state_next        = ST_DRAIN;
            drain_next        = DRAIN_LOAD;
          end else if (bus.i_take) begin
            bus.o_if_id_flush = 1'b1;
          end
        end
        ST_DRAIN: begin
          bus.o_risk        = 1'b1;
          bus.o_pc_write    = 1'b0;
          bus.o_if_id_write = 1'b0;
          bus.o_if_id_flush = 1'b1;
          if (drain_cnt == '0) state_next = ST_HALTED;
          else                 drain_next = drain_cnt - 1'b1;
        end
        ST_HALTED: begin
          bus.o_risk        = 1'b1;
          bus.o_pc_write    = 1'b0;
          bus.o_if_id_write = 1'b0;
          bus.o_halted      = 1'b1;
        end
        default: state_next = ST_RUN;
      endcase
    end
  end

  assign bus.o_dbg_state = state;

`ifdef RISK_STALL_COUNT_EN
  logic [CNT_W-1:0] stall_cnt;
  logic             stall_inc;

  assign stall_inc = i_enable && (state == ST_RUN) && hz_stall;

  always_ff @(posedge i_clk) begin
    if (i_reset)                            stall_cnt <= '0;
    else if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
  end

  assign bus.o_stall_count = stall_cnt;
`else
  assign bus.o_stall_count = '0;
`endif

endmodule

// File: doc/unit_risk_ctrl.md
Name: unit_risk_ctrl

Overview:
Hazard-detection and front-end sequencing controller for the 5-stage MIPS pipeline. Detects load-use and branch-operand hazards on the IF/ID instruction and drives the risk bubble into the control-signal hazard mux. Gates PC and IF/ID writes, flushes IF/ID on taken control transfers, and sequences the halt drain so the pipeline empties before the core reports halted.

Parameters:
REG_ADDR_W, 5, register address width
DRAIN_CYCLES, 4, bubble cycles inserted after HALT is accepted (ID→WB depth)
CNT_W, 32, width of the stall performance counter

Ports:
i_clk  in  1  clock, all state updates on rising edge
i_reset  in  1  synchronous active-high reset
i_enable  in  1  debug-unit run/step enable; low freezes the controller
i_if_id_rs  in  REG_ADDR_W  rs of instruction in ID
i_if_id_rt  in  REG_ADDR_W  rt of instruction in ID
i_uses_rt  in  1  ID instruction reads rt (R-type, store, branch)
i_id_branch  in  1  ID instruction is beq/bne/jr/jalr (operands compared/used in ID)
i_id_ex_mem_read  in  1  instruction in EX is a load
i_id_ex_reg_write  in  1  instruction in EX writes a register
i_id_ex_dst  in  REG_ADDR_W  destination register of EX instruction
i_ex_mem_mem_read  in  1  instruction in MEM is a load
i_ex_mem_dst  in  REG_ADDR_W  destination register of MEM instruction
i_take  in  1  ID resolved taken branch or jump/jal/jr/jalr
i_halt  in  1  ID instruction is HALT
o_risk  out  1  bubble request to the hazard mux (zeros control)
o_pc_write  out  1  PC write enable
o_if_id_write  out  1  IF/ID register write enable
o_if_id_flush  out  1  clear IF/ID to NOP on next edge
o_halted  out  1  pipeline fully drained after HALT
o_stall_count  out  CNT_W  cumulative stall cycles (see Optional Feature)

Behaviour:
- Hazard terms (combinational; register 0 never matches):
  - LU: i_id_ex_mem_read & dst≠0 & (dst==rs | (i_uses_rt & dst==rt)).
  - BR1: i_id_branch & i_id_ex_reg_write & same dst match on i_id_ex_dst.
  - BR2: i_id_branch & i_ex_mem_mem_read & match on i_ex_mem_dst.
  - stall = LU | BR1 | BR2.
- FSM states: RUN, DRAIN, HALTED. Reset → RUN, drain counter 0, stall counter 0.
- Reset values of outputs: o_risk=0, o_pc_write=1, o_if_id_write=1, o_if_id_flush=0, o_halted=0, o_stall_count=0.
- Priority each cycle: i_reset > !i_enable > state HALTED > stall > i_halt > i_take.
- !i_enable (any state):
  - o_pc_write=0, o_if_id_write=0, o_risk=0, o_if_id_flush=0.
  - FSM, counters hold.
- RUN:
  - stall: o_risk=1, o_pc_write=0, o_if_id_write=0, o_if_id_flush=0. i_halt and i_take are ignored this cycle; they are re-evaluated once the stall clears. BR2 naturally lasts 2 cycles (becomes BR1-free LU-free only after load reaches WB).
  - else i_halt: next state DRAIN, counter loaded DRAIN_CYCLES-1. This cycle: o_pc_write=0, o_if_id_write=0, o_risk=0 (HALT itself proceeds).
  - else i_take: o_if_id_flush=1, o_pc_write=1, o_if_id_write=1, o_risk=0 (1-cycle delay-slot squash).
  - else: all pass (risk=0, writes=1, flush=0).
- DRAIN:
  - o_risk=1, o_pc_write=0, o_if_id_write=0, o_if_id_flush=1.
  - Counter decrements each enabled cycle; at 0 → HALTED.
- HALTED:
  - o_halted=1, o_risk=1, writes=0.
  - Leaves only via i_reset.
- Stall counter: +1 on every enabled cycle in RUN with stall=1; saturates at all-ones.
- Reset mid-DRAIN or mid-stall: returns to RUN on next edge with reset values; no residual flush.

Optional Feature:
- Macro RISK_STALL_COUNT_EN.
- Defined: o_stall_count is the saturating counter described above.
- Undefined: counter logic is omitted and o_stall_count is tied to 0.

Decomposition:
- Shared package pipeline_pkg holds:
  - REG_ADDR_W
  - FSM state encoding (RUN=2'b00, DRAIN=2'b01, HALTED=2'b10)
  - default DRAIN_CYCLES constant
- Natural sub-module: risk_detect, purely combinational LU/BR1/BR2 comparison, reusable by the forwarding unit.
- FSM and counters stay in unit_risk_ctrl.

Test Plan:
- Load-use: EX=lw $3, ID=add $4,$3,$5 → one cycle with o_risk=1, o_pc_write=0, o_if_id_write=0, then normal flow.
- Branch after load: lw $2 followed by beq $2,$0 → o_risk=1 for exactly 2 cycles, stall_count +2; with dst=$0 instead → no stall.
- Taken jump in ID, no hazard → o_if_id_flush=1 for 1 cycle, PC written; concurrent LU with i_take → stall wins, flush deferred until stall clears.
- HALT with DRAIN_CYCLES=4 → 4 DRAIN cycles with o_risk=1, then o_halted=1 held indefinitely; o_pc_write=0 throughout.
- i_enable low for 3 cycles during DRAIN → counter frozen, total DRAIN cycles still 4.
- i_reset asserted in HALTED and mid-DRAIN → next cycle RUN, all outputs at reset values, stall_count=0.
